// File: rtl/mux4x1.sv
`default_nettype none
// ============================================================================
//  Module      : mux4x1
//  Description : 4-to-1 selector with a zero-latency combinational output and
//                a registered copy (out_q) carrying a one-cycle valid strobe
//                and the select code it was captured with.
//                Optional feature macro MUX4X1_SEL_CNT_EN adds sel_chg_cnt, a
//                saturating count of captures whose select differs from the
//                previously captured select.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4x1 #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] l,
   input  logic [WIDTH-1:0] m,
   input  logic [1:0]       sel,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_vld,
   output logic [1:0]       sel_q
`ifdef MUX4X1_SEL_CNT_EN
   ,
   output logic [7:0]       sel_chg_cnt
`endif
);

   logic [WIDTH-1:0] out_d;
   logic [1:0]       sel_d;
   logic             vld_d;

   // Select decode; an unknown select propagates as all-X so simulation
   // exposes it instead of silently picking an input.
   always_comb begin
      out = {WIDTH{1'bx}};
      case (sel)
         2'b00:   out = j;
         2'b01:   out = k;
         2'b10:   out = l;
         2'b11:   out = m;
         default: out = {WIDTH{1'bx}};
      endcase
   end

   // Capture path next state: load on enable, otherwise hold and drop strobe.
   always_comb begin
      out_d = out_q;
      sel_d = sel_q;
      vld_d = 1'b0;
      if (en) begin
         out_d = out;
         sel_d = sel;
         vld_d = 1'b1;
      end
   end

   // Capture registers with immediate (asynchronous) reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= RST_VAL;
         sel_q   <= 2'b00;
         out_vld <= 1'b0;
      end else begin
         out_q   <= out_d;
         sel_q   <= sel_d;
         out_vld <= vld_d;
      end
   end

`ifdef MUX4X1_SEL_CNT_EN
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Count captures that change the select relative to sel_q; stick at max.
   always_comb begin
      cnt_d = cnt_q;
      if (en && (sel != sel_q) && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sel_chg_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux4x1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux4x1
//  Description : Self-checking bench for mux4x1 (WIDTH=1 and WIDTH=8
//                instances). Covers MUX4X1_SEL_CNT_EN when that macro is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4x1;

   localparam logic [7:0] c_RST8 = 8'h3C;

   logic       clk;
   logic       rst_n;
   logic [1:0] sel;
   logic       en;
   logic       j1, k1, l1, m1;
   logic [7:0] j8, k8, l8, m8;

   logic       out1, oq1, vld1;
   logic [1:0] sq1;
   logic [7:0] out8, oq8;
   logic       vld8;
   logic [1:0] sq8;
`ifdef MUX4X1_SEL_CNT_EN
   logic [7:0] cnt1, cnt8;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   logic       m_oq1;
   logic [7:0] m_oq8;
   logic [1:0] m_sel;
   logic       m_vld;
   int         m_cnt;

   typedef struct {
      logic [1:0] s;
      logic       vj, vk, vl, vm;
      logic       exp;
   } vec_t;
   vec_t tbl[4];

   mux4x1 #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .j(j1), .k(k1), .l(l1), .m(m1),
      .sel(sel), .en(en), .out(out1), .out_q(oq1), .out_vld(vld1), .sel_q(sq1)
`ifdef MUX4X1_SEL_CNT_EN
      , .sel_chg_cnt(cnt1)
`endif
   );

   mux4x1 #(.WIDTH(8), .RST_VAL(c_RST8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .j(j8), .k(k8), .l(l8), .m(m8),
      .sel(sel), .en(en), .out(out8), .out_q(oq8), .out_vld(vld8), .sel_q(sq8)
`ifdef MUX4X1_SEL_CNT_EN
      , .sel_chg_cnt(cnt8)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // selection as an array lookup
   function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c,
                                       input logic [7:0] d);
      logic [7:0] v[4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      return v[s];
   endfunction

   task automatic model_reset();
      m_oq1 = 1'b0;
      m_oq8 = c_RST8;
      m_sel = 2'b00;
      m_vld = 1'b0;
      m_cnt = 0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".out1"},  {31'd0, out1}, {31'd0, pick(sel, {7'd0, j1}, {7'd0, k1}, {7'd0, l1}, {7'd0, m1}) & 8'h01});
      check({tag, ".out8"},  {24'd0, out8}, {24'd0, pick(sel, j8, k8, l8, m8)});
      check({tag, ".oq1"},   {31'd0, oq1},  {31'd0, m_oq1});
      check({tag, ".oq8"},   {24'd0, oq8},  {24'd0, m_oq8});
      check({tag, ".sq1"},   {30'd0, sq1},  {30'd0, m_sel});
      check({tag, ".sq8"},   {30'd0, sq8},  {30'd0, m_sel});
      check({tag, ".vld1"},  {31'd0, vld1}, {31'd0, m_vld});
      check({tag, ".vld8"},  {31'd0, vld8}, {31'd0, m_vld});
`ifdef MUX4X1_SEL_CNT_EN
      check({tag, ".cnt1"},  {24'd0, cnt1}, m_cnt);
      check({tag, ".cnt8"},  {24'd0, cnt8}, m_cnt);
`endif
   endtask

   // One rising edge with inputs held stable; model advances, then compare.
   task automatic tick(input string tag);
      logic [1:0] s_pre;
      s_pre = sel;
      @(posedge clk);
      #1;
      if (en) begin
         if (s_pre != m_sel && m_cnt < 255) m_cnt++;
         m_oq1 = pick(s_pre, {7'd0, j1}, {7'd0, k1}, {7'd0, l1}, {7'd0, m1}) & 8'h01;
         m_oq8 = pick(s_pre, j8, k8, l8, m8);
         m_sel = s_pre;
         m_vld = 1'b1;
      end else begin
         m_vld = 1'b0;
      end
      check_state(tag);
   endtask

   // Assert reset between edges, check immediately, release before next edge.
   task automatic mid_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_state(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0] = '{s: 2'b00, vj: 1'b0, vk: 1'b1, vl: 1'b0, vm: 1'b1, exp: 1'b0};
      tbl[1] = '{s: 2'b01, vj: 1'b1, vk: 1'b1, vl: 1'b0, vm: 1'b1, exp: 1'b1};
      tbl[2] = '{s: 2'b10, vj: 1'b0, vk: 1'b0, vl: 1'b0, vm: 1'b1, exp: 1'b0};
      tbl[3] = '{s: 2'b11, vj: 1'b1, vk: 1'b1, vl: 1'b1, vm: 1'b1, exp: 1'b1};

      rst_n = 1'b0;
      en    = 1'b0;
      sel   = 2'b00;
      {j1, k1, l1, m1} = 4'b0000;
      {j8, k8, l8, m8} = 32'd0;
      model_reset();

      // reset state
      #7;
      check_state("reset");

      // combinational decode while held in reset, no clock dependence
      for (int i = 0; i < 4; i++) begin
         sel = tbl[i].s;
         j1 = tbl[i].vj; k1 = tbl[i].vk; l1 = tbl[i].vl; m1 = tbl[i].vm;
         #5;
         check($sformatf("comb%0d", i), {31'd0, out1}, {31'd0, tbl[i].exp});
      end
      check("comb_rst_oq1", {31'd0, oq1}, 32'd0);

      // release reset away from an edge
      @(negedge clk);
      rst_n = 1'b1;

      // registered capture then hold
      sel = 2'b11; j1 = 1'b0; k1 = 1'b0; l1 = 1'b0; m1 = 1'b1; en = 1'b1;
      tick("cap");
      check("cap_oq1", {31'd0, oq1}, 32'd1);
      check("cap_sq1", {30'd0, sq1}, 32'd3);
      check("cap_vld", {31'd0, vld1}, 32'd1);
      en = 1'b0;
      tick("hold");
      check("hold_oq1", {31'd0, oq1}, 32'd1);
      check("hold_vld", {31'd0, vld1}, 32'd0);

      // asynchronous reset between edges
      mid_reset("areset");
      check("areset_oq1", {31'd0, oq1}, 32'd0);
      check("areset_out1", {31'd0, out1}, 32'd1);

      // per-bit independence sweep, WIDTH=8
      j8 = 8'hA5; k8 = 8'h5A; l8 = 8'hFF; m8 = 8'h00;
      en = 1'b1;
      begin
         logic [7:0] exp8[4];
         exp8[0] = 8'hA5; exp8[1] = 8'h5A; exp8[2] = 8'hFF; exp8[3] = 8'h00;
         for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check($sformatf("sweep_out8_%0d", s), {24'd0, out8}, {24'd0, exp8[s]});
            tick("sweep");
            check($sformatf("sweep_oq8_%0d", s), {24'd0, oq8}, {24'd0, exp8[s]});
         end
      end

      // back-to-back enables keep the strobe high
      sel = 2'b01; tick("b2b0");
      sel = 2'b10; tick("b2b1");
      check("b2b_vld", {31'd0, vld8}, 32'd1);

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         sel = 2'($urandom_range(0, 3));
         en  = 1'($urandom_range(0, 1));
         j1 = 1'($urandom); k1 = 1'($urandom); l1 = 1'($urandom); m1 = 1'($urandom);
         j8 = 8'($urandom); k8 = 8'($urandom); l8 = 8'($urandom); m8 = 8'($urandom);
         tick("rand");
         if (i % 97 == 50) mid_reset("rand_rst");
      end

`ifdef MUX4X1_SEL_CNT_EN
      // select-change counter
      mid_reset("cnt_rst");
      en = 1'b1;
      begin
         logic [1:0] seq[5];
         seq[0] = 2'b00; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b11; seq[4] = 2'b11;
         for (int i = 0; i < 5; i++) begin
            sel = seq[i];
            tick("cnt_seq");
         end
      end
      check("cnt_two", {24'd0, cnt1}, 32'd2);
      for (int i = 0; i < 300; i++) begin
         sel = i[0] ? 2'b11 : 2'b00;
         tick("cnt_sat");
      end
      check("cnt_sat1", {24'd0, cnt1}, 32'hFF);
      check("cnt_sat8", {24'd0, cnt8}, 32'hFF);
      mid_reset("cnt_clr");
      check("cnt_clr", {24'd0, cnt1}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
